// File: rtl/mem_access_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_access_arbiter_pkg
// Shared definitions for the external memory port arbiter.
//   - arb_state_t  : sequencer states (IDLE / ACCESS / RELEASE)
//   - RWZZ_*       : encodings driven on MEM_r_w_z_z
//   - GNT_*        : requester ids used for the grant / last-grant bit
//   - pick_data()  : arbitration rule between fetch and data requesters
// -----------------------------------------------------------------------------
package mem_access_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        RELEASE = 2'd2
    } arb_state_t;

    localparam logic [1:0] RWZZ_READ  = 2'b00;
    localparam logic [1:0] RWZZ_WRITE = 2'b01;
    localparam logic [1:0] RWZZ_HIZ   = 2'b10;

    localparam logic GNT_FETCH = 1'b0;
    localparam logic GNT_DATA  = 1'b1;

    // A lone requester always wins; under contention the requester that was
    // not granted last goes first, so neither side can be starved.
    function automatic logic pick_data(input logic fetch_req,
                                       input logic data_req,
                                       input logic last_grant);
        return data_req && (!fetch_req || (last_grant == GNT_FETCH));
    endfunction

endpackage

// File: rtl/mem_access_arbiter_timeout_counter.sv
// -----------------------------------------------------------------------------
// mem_timeout_counter
// Counts cycles spent in one memory access and flags when the memory has
// failed to answer within TIMEOUT_CYCLES cycles. Only instantiated when the
// arbiter is built with MEM_TIMEOUT_EN.
//   clk, rst  : clock, asynchronous active-high reset
//   clear     : restart the count (any cycle outside an access)
//   enable    : count this cycle (access in progress)
//   expired   : this is the last cycle the access is allowed to wait
// -----------------------------------------------------------------------------
module mem_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] count;

    // count holds the index of the current access cycle, starting at 0.
    assign expired = enable && (count == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/mem_access_arbiter.sv
// -----------------------------------------------------------------------------
// mem_access_arbiter
// Shares the single external memory port between instruction fetch and the
// memory-stage data path. Every access runs IDLE -> ACCESS -> RELEASE so the
// memory always sees a bus release between back-to-back accesses.
//
// Build option: define MEM_TIMEOUT_EN to abort an access that sees neither
// MEM_MFC nor MEM_ERROR within TIMEOUT_CYCLES cycles (reported as an error).
// Without it the access waits indefinitely.
//
// Ports:
//   Clock, Reset                      clock, async active-high reset
//   Fetch_Req/Address                 fetch read request (PC)
//   Fetch_Done/Data                   completion pulse, read word (held)
//   Data_Req/Write/Address/Wdata      data request (RZ address, RM data)
//   Data_Done/Rdata                   completion pulse, read word (held)
//   Access_Error                      accompanies a Done pulse on failure
//   Error_Sticky                      any failure since reset
//   Stall                             a request is still outstanding
//   MEM_Address/Data_In/r_w_z_z       registered memory command
//   MEM_Data_Out/MFC/ERROR            memory response
// -----------------------------------------------------------------------------
module mem_access_arbiter
    import mem_access_arbiter_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 15,
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Fetch_Req,
    input  logic [ADDR_W-1:0] Fetch_Address,
    output logic              Fetch_Done,
    output logic [DATA_W-1:0] Fetch_Data,
    input  logic              Data_Req,
    input  logic              Data_Write,
    input  logic [ADDR_W-1:0] Data_Address,
    input  logic [DATA_W-1:0] Data_Wdata,
    output logic              Data_Done,
    output logic [DATA_W-1:0] Data_Rdata,
    output logic              Access_Error,
    output logic              Error_Sticky,
    output logic              Stall,
    output logic [ADDR_W-1:0] MEM_Address,
    output logic [DATA_W-1:0] MEM_Data_In,
    output logic [1:0]        MEM_r_w_z_z,
    input  logic [DATA_W-1:0] MEM_Data_Out,
    input  logic              MEM_MFC,
    input  logic              MEM_ERROR
);

    // A zero-length timeout would abort accesses before memory could answer.
    if (TIMEOUT_CYCLES < 1) begin : g_timeout_range
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    arb_state_t state;
    arb_state_t state_next;

    // Requester owning the current access; it is also the last-grant bit used
    // by the arbitration rule for the next contention.
    logic grant;

    logic win_data;
    logic start;
    logic finish;
    logic fail;
    logic timeout_hit;

`ifdef MEM_TIMEOUT_EN
    mem_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (Clock),
        .rst    (Reset),
        .clear  (state != ACCESS),
        .enable (state == ACCESS),
        .expired(timeout_hit)
    );
`else
    assign timeout_hit = 1'b0;
`endif

    // Next-state and access-event decode.
    always_comb begin
        state_next = state;
        start      = 1'b0;
        finish     = 1'b0;
        fail       = 1'b0;
        win_data   = pick_data(Fetch_Req, Data_Req, grant);
        case (state)
            IDLE: begin
                if (Fetch_Req || Data_Req) begin
                    start      = 1'b1;
                    state_next = ACCESS;
                end
            end
            ACCESS: begin
                // ERROR outranks MFC; a timeout is reported as an ERROR.
                if (MEM_ERROR || timeout_hit) begin
                    finish     = 1'b1;
                    fail       = 1'b1;
                    state_next = RELEASE;
                end else if (MEM_MFC) begin
                    finish     = 1'b1;
                    state_next = RELEASE;
                end
            end
            RELEASE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Memory command registers, completion pulses and returned data.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            grant        <= GNT_FETCH;
            MEM_Address  <= '0;
            MEM_Data_In  <= '0;
            MEM_r_w_z_z  <= RWZZ_HIZ;
            Fetch_Done   <= 1'b0;
            Data_Done    <= 1'b0;
            Access_Error <= 1'b0;
            Error_Sticky <= 1'b0;
            Fetch_Data   <= '0;
            Data_Rdata   <= '0;
        end else begin
            Fetch_Done   <= 1'b0;
            Data_Done    <= 1'b0;
            Access_Error <= 1'b0;

            if (start) begin
                grant <= win_data ? GNT_DATA : GNT_FETCH;
                if (win_data) begin
                    MEM_Address <= Data_Address;
                    if (Data_Write) begin
                        MEM_Data_In <= Data_Wdata;
                        MEM_r_w_z_z <= RWZZ_WRITE;
                    end else begin
                        MEM_r_w_z_z <= RWZZ_READ;
                    end
                end else begin
                    MEM_Address <= Fetch_Address;
                    MEM_r_w_z_z <= RWZZ_READ;
                end
            end

            if (finish) begin
                MEM_r_w_z_z  <= RWZZ_HIZ;
                Fetch_Done   <= (grant == GNT_FETCH);
                Data_Done    <= (grant == GNT_DATA);
                Access_Error <= fail;
                if (fail) begin
                    Error_Sticky <= 1'b1;
                end else if (MEM_r_w_z_z == RWZZ_READ) begin
                    // Only successful reads update the requester's data.
                    if (grant == GNT_DATA) begin
                        Data_Rdata <= MEM_Data_Out;
                    end else begin
                        Fetch_Data <= MEM_Data_Out;
                    end
                end
            end
        end
    end

    // Drops in the Done cycle so the pipeline advances without a bubble.
    assign Stall = (Fetch_Req && !Fetch_Done) || (Data_Req && !Data_Done);

endmodule

// File: tb/tb_mem_access_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_access_arbiter
// Self-checking bench for mem_access_arbiter. A transaction-level model keeps
// the arbitration history, the held read words and the sticky error flag;
// the bench plays the memory and checks the port timing cycle by cycle.
// -----------------------------------------------------------------------------
module tb_mem_access_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          fetch_req;
    logic [AW-1:0] fetch_address;
    logic          fetch_done;
    logic [DW-1:0] fetch_data;
    logic          data_req;
    logic          data_write;
    logic [AW-1:0] data_address;
    logic [DW-1:0] data_wdata;
    logic          data_done;
    logic [DW-1:0] data_rdata;
    logic          access_error;
    logic          error_sticky;
    logic          stall;
    logic [AW-1:0] mem_address;
    logic [DW-1:0] mem_data_in;
    logic [1:0]    mem_rwzz;
    logic [DW-1:0] mem_data_out;
    logic          mem_mfc;
    logic          mem_error;

    mem_access_arbiter #(
        .TIMEOUT_CYCLES(TO),
        .ADDR_W        (AW),
        .DATA_W        (DW)
    ) dut (
        .Clock        (clk),
        .Reset        (rst),
        .Fetch_Req    (fetch_req),
        .Fetch_Address(fetch_address),
        .Fetch_Done   (fetch_done),
        .Fetch_Data   (fetch_data),
        .Data_Req     (data_req),
        .Data_Write   (data_write),
        .Data_Address (data_address),
        .Data_Wdata   (data_wdata),
        .Data_Done    (data_done),
        .Data_Rdata   (data_rdata),
        .Access_Error (access_error),
        .Error_Sticky (error_sticky),
        .Stall        (stall),
        .MEM_Address  (mem_address),
        .MEM_Data_In  (mem_data_in),
        .MEM_r_w_z_z  (mem_rwzz),
        .MEM_Data_Out (mem_data_out),
        .MEM_MFC      (mem_mfc),
        .MEM_ERROR    (mem_error)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference state: who was granted last, held read words, sticky error.
    bit            m_last_data;
    logic [DW-1:0] m_fetch_data;
    logic [DW-1:0] m_data_rdata;
    bit            m_sticky;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_last_data  = 1'b0;
        m_fetch_data = '0;
        m_data_rdata = '0;
        m_sticky     = 1'b0;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_rwzz"}, mem_rwzz, 2'b10);
        chk({tag, "_done"}, {fetch_done, data_done, access_error}, 3'b000);
    endtask

    // One access started from IDLE at a negedge. err_mode: 0 MFC only,
    // 1 ERROR only, 2 ERROR and MFC together. Ends at a negedge in IDLE.
    task automatic run_txn(input bit fr, input bit dr, input bit dw,
                           input logic [AW-1:0] fa, input logic [AW-1:0] da,
                           input logic [DW-1:0] wd, input logic [DW-1:0] rd,
                           input int delay, input int err_mode);
        bit            win_data;
        bit            win_write;
        bit            failed;
        logic [1:0]    exp_code;
        logic [AW-1:0] exp_addr;
        win_data  = dr && (!fr || !m_last_data);
        win_write = win_data && dw;
        failed    = (err_mode != 0);
        exp_code  = win_write ? 2'b01 : 2'b00;
        exp_addr  = win_data ? da : fa;

        fetch_req     = fr;
        data_req      = dr;
        data_write    = dw;
        fetch_address = fa;
        data_address  = da;
        data_wdata    = wd;
        #1;
        chk("stall_req", stall, 1'b1);

        @(negedge clk);
        chk("acc_rwzz", mem_rwzz, exp_code);
        chk("acc_addr", mem_address, exp_addr);
        if (win_write) chk("acc_wdata", mem_data_in, wd);
        // Inputs other than at grant must not disturb the active access.
        fetch_address = $urandom;
        data_address  = $urandom;
        data_wdata    = $urandom;
        data_write    = ~dw;
        for (int i = 0; i < delay; i++) begin
            chk("wait_no_done", {fetch_done, data_done}, 2'b00);
            @(negedge clk);
        end
        chk("hold_rwzz", mem_rwzz, exp_code);
        chk("hold_addr", mem_address, exp_addr);
        if (win_write) chk("hold_wdata", mem_data_in, wd);
        mem_mfc      = (err_mode != 1);
        mem_error    = failed;
        mem_data_out = rd;

        @(negedge clk);
        mem_mfc      = 1'b0;
        mem_error    = 1'b0;
        mem_data_out = $urandom;
        m_last_data  = win_data;
        if (failed) m_sticky = 1'b1;
        else if (!win_write) begin
            if (win_data) m_data_rdata = rd;
            else          m_fetch_data = rd;
        end
        chk("fetch_done", fetch_done, !win_data);
        chk("data_done", data_done, win_data);
        chk("access_error", access_error, failed);
        chk("error_sticky", error_sticky, m_sticky);
        chk("fetch_data", fetch_data, m_fetch_data);
        chk("data_rdata", data_rdata, m_data_rdata);
        chk("rel_rwzz", mem_rwzz, 2'b10);
        chk("stall_done", stall, win_data ? fr : dr);
        fetch_req = 1'b0;
        data_req  = 1'b0;
        #1;
        chk("stall_clear", stall, 1'b0);

        @(negedge clk);
        chk_quiet("idle");
    endtask

    int hang_hits;

    initial begin
        rst           = 1'b1;
        fetch_req     = 1'b0;
        fetch_address = '0;
        data_req      = 1'b0;
        data_write    = 1'b0;
        data_address  = '0;
        data_wdata    = '0;
        mem_data_out  = '0;
        mem_mfc       = 1'b0;
        mem_error     = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        chk_quiet("reset");
        chk("reset_addr", mem_address, '0);
        chk("reset_wdata", mem_data_in, '0);
        chk("reset_fdata", fetch_data, '0);
        chk("reset_rdata", data_rdata, '0);
        chk("reset_sticky", error_sticky, 1'b0);
        chk("reset_stall", stall, 1'b0);

        // Both requests held: grants alternate data, fetch, data, fetch.
        fetch_req     = 1'b1;
        data_req      = 1'b1;
        data_write    = 1'b0;
        fetch_address = 32'h100;
        data_address  = 32'h200;
        for (int k = 0; k < 4; k++) begin
            bit            wd_k;
            logic [DW-1:0] rd_k;
            wd_k = !m_last_data;
            rd_k = $urandom;
            @(negedge clk);
            chk("alt_rwzz", mem_rwzz, 2'b00);
            chk("alt_addr", mem_address, wd_k ? 32'h200 : 32'h100);
            chk("alt_stall", stall, 1'b1);
            mem_mfc      = 1'b1;
            mem_data_out = rd_k;
            @(negedge clk);
            mem_mfc = 1'b0;
            m_last_data = wd_k;
            if (wd_k) m_data_rdata = rd_k;
            else      m_fetch_data = rd_k;
            chk("alt_done", {fetch_done, data_done}, {!wd_k, wd_k});
            chk("alt_fdata", fetch_data, m_fetch_data);
            chk("alt_rdata", data_rdata, m_data_rdata);
            chk("alt_rel", mem_rwzz, 2'b10);
            @(negedge clk);
            chk("alt_idle", mem_rwzz, 2'b10);
        end
        fetch_req = 1'b0;
        data_req  = 1'b0;
        @(negedge clk);
        @(negedge clk);

        // Directed cases from the access rules.
        run_txn(1, 0, 0, 32'h10, 32'h0, 32'h0, 32'hDEADBEEF, 2, 0);
        run_txn(0, 1, 1, 32'h0, 32'h20, 32'h12345678, 32'hA5A5A5A5, 0, 0);
        run_txn(0, 1, 0, 32'h0, 32'h24, 32'h0, 32'h0BADF00D, 1, 2);

        // Randomized traffic.
        for (int t = 0; t < 40; t++) begin
            bit fr;
            bit dr;
            int em;
            fr = $urandom_range(0, 1);
            dr = $urandom_range(0, 1);
            if (!fr && !dr) fr = 1'b1;
            em = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 2)) : 0;
            run_txn(fr, dr, 1'($urandom_range(0, 1)), $urandom, $urandom, $urandom,
                    $urandom, int'($urandom_range(0, 3)), em);
        end

        // Memory that never answers.
        fetch_req     = 1'b1;
        fetch_address = 32'h44;
        @(negedge clk);
`ifdef MEM_TIMEOUT_EN
        for (int i = 0; i < TO; i++) begin
            chk("to_wait_done", fetch_done, 1'b0);
            chk("to_wait_rwzz", mem_rwzz, 2'b00);
            @(negedge clk);
        end
        m_sticky    = 1'b1;
        m_last_data = 1'b0;
        chk("to_done", fetch_done, 1'b1);
        chk("to_error", access_error, 1'b1);
        chk("to_sticky", error_sticky, 1'b1);
        chk("to_fdata", fetch_data, m_fetch_data);
        fetch_req = 1'b0;
        @(negedge clk);
`else
        hang_hits = 0;
        for (int i = 0; i < 100; i++) begin
            if (fetch_done || mem_rwzz != 2'b00) hang_hits++;
            @(negedge clk);
        end
        chk("hang_wait", hang_hits, 0);
        mem_mfc      = 1'b1;
        mem_data_out = 32'hCAFE0001;
        @(negedge clk);
        mem_mfc      = 1'b0;
        m_fetch_data = 32'hCAFE0001;
        m_last_data  = 1'b0;
        chk("hang_done", fetch_done, 1'b1);
        chk("hang_fdata", fetch_data, m_fetch_data);
        fetch_req = 1'b0;
        @(negedge clk);
`endif
        chk_quiet("post_hang");

        // Make sure there is state to clear, then reset in the middle of an access.
        run_txn(0, 1, 0, 32'h0, 32'h30, 32'h0, 32'h77, 0, 1);
        fetch_req     = 1'b1;
        fetch_address = 32'h50;
        @(negedge clk);
        chk("pre_rst_rwzz", mem_rwzz, 2'b00);
        #2 rst = 1'b1;
        #1;
        model_reset();
        chk_quiet("mid_rst");
        chk("mid_rst_addr", mem_address, '0);
        chk("mid_rst_wdata", mem_data_in, '0);
        chk("mid_rst_fdata", fetch_data, m_fetch_data);
        chk("mid_rst_rdata", data_rdata, m_data_rdata);
        chk("mid_rst_sticky", error_sticky, m_sticky);
        @(negedge clk);
        chk_quiet("in_rst");
        rst = 1'b0;
        run_txn(1, 0, 0, 32'h50, 32'h0, 32'h0, 32'h13572468, 1, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_access_arbiter.md
# mem_access_arbiter

Sequences all accesses to the single external memory port, sharing it between the instruction-fetch requester (PC address into IR) and the memory-stage data requester (RZ address, RM write data, MuxY read data). Owns the MEM_MFC / MEM_ERROR handshake, drives MEM_r_w_z_z, and raises Stall so the control signal generator holds the pipeline while an access is outstanding.

## Interface
- TIMEOUT_CYCLES, 15: cycles in ACCESS without MFC/ERROR before a forced error (only with MEM_TIMEOUT_EN).
- ADDR_W, 32: address width.
- DATA_W, 32: data width.

- Clock  in  1  single clock, all state on rising edge.
- Reset  in  1  asynchronous, active-high; clears all state immediately.
- Fetch_Req  in  1  level; fetch wants a read at Fetch_Address.
- Fetch_Address  in  ADDR_W  word address (PC).
- Fetch_Done  out  1  one-cycle pulse: fetch access finished.
- Fetch_Data  out  DATA_W  read word, valid while Fetch_Done=1 and held until next fetch completion.
- Data_Req  in  1  level; memory stage wants an access.
- Data_Write  in  1  1=write, 0=read; sampled at grant.
- Data_Address  in  ADDR_W  word address (RZ).
- Data_Wdata  in  DATA_W  write data (RM).
- Data_Done  out  1  one-cycle pulse: data access finished.
- Data_Rdata  out  DATA_W  read word, valid while Data_Done=1 and held.
- Access_Error  out  1  with a Done pulse: that access failed (ERROR or timeout).
- Error_Sticky  out  1  set on any failed access; cleared only by Reset.
- Stall  out  1  1 whenever any Req is high and its Done has not yet pulsed.
- MEM_Address  out  ADDR_W  registered address to memory.
- MEM_Data_In  out  DATA_W  registered write data to memory.
- MEM_r_w_z_z  out  2  00 read, 01 write, 10 release (high-Z).
- MEM_Data_Out  in  DATA_W  memory read data.
- MEM_MFC  in  1  memory function complete.
- MEM_ERROR  in  1  access failed.

## Operation
- States: IDLE, ACCESS, RELEASE.
- IDLE: MEM_r_w_z_z=10. If any Req: pick winner, latch address/write/wdata into MEM_* registers, go ACCESS.
- Arbitration: only one Req -> it wins. Both -> the one not granted last (Last_Grant bit, reset value = fetch, so first contention goes to data).
- ACCESS: MEM_r_w_z_z=00 (fetch or data read) or 01 (data write); address/data held constant. Each cycle sample MEM_MFC, MEM_ERROR.
  - MEM_ERROR=1 (priority over MFC): Done pulse for winner with Access_Error=1, set Error_Sticky, go RELEASE.
  - MEM_MFC=1: capture MEM_Data_Out into winner's data register (reads only; writes leave it unchanged), Done pulse, go RELEASE.
  - Timeout (if enabled): treated exactly as MEM_ERROR.
- RELEASE: MEM_r_w_z_z=10 for one cycle, then IDLE. Guarantees memory sees a bus release between back-to-back accesses.
- Req dropped during ACCESS: access still completes; Done still pulses. Req inputs other than at grant are ignored for the active access.
- Reset mid-access: return to IDLE at once, no Done pulse, MEM_r_w_z_z=10; requester re-issues.
- Reset values: state IDLE, MEM_r_w_z_z=10, MEM_Address=0, MEM_Data_In=0, Fetch_Data=0, Data_Rdata=0, all Done=0, Access_Error=0, Error_Sticky=0, Last_Grant=fetch, timeout counter 0. Stall is combinational from Req and state.

## Timing
- Req high in IDLE at edge N -> ACCESS with MEM_* driven from edge N+1.
- MFC/ERROR sampled high at edge M -> Done (+ data/Access_Error) valid from edge M+1 for one cycle (state RELEASE).
- IDLE again from edge M+2; next ACCESS earliest from M+3. Minimum access = 3 cycles with MFC in first ACCESS cycle.
- Timeout counter: counts ACCESS cycles from 0; error taken when count reaches TIMEOUT_CYCLES-1 with no MFC/ERROR, i.e. Done at ACCESS entry + TIMEOUT_CYCLES.
- Stall drops in the same cycle the requester's Done is high if that Req is the only one high (Req deasserted next cycle by requester).

## Configuration
- MEM_TIMEOUT_EN defined: timeout counter present; hung memory yields Access_Error after TIMEOUT_CYCLES.
- Not defined: no counter, ACCESS waits indefinitely for MEM_MFC or MEM_ERROR; TIMEOUT_CYCLES unused.

## Structure
- Shared package: state enum (IDLE/ACCESS/RELEASE), MEM_r_w_z_z codes RWZZ_READ=2'b00, RWZZ_WRITE=2'b01, RWZZ_HIZ=2'b10, grant-id constants GNT_FETCH/GNT_DATA.
- Sub-module mem_timeout_counter (clear, enable, expired), instantiated only under MEM_TIMEOUT_EN.

## Test plan
- Fetch_Req only, addr 0x10, MFC 2 cycles into ACCESS with data 0xDEADBEEF -> MEM_r_w_z_z=00, Fetch_Done one pulse, Fetch_Data=0xDEADBEEF, then 10 for one cycle.
- Data write addr 0x20 data 0x12345678, MFC in first ACCESS cycle -> MEM_r_w_z_z=01, MEM_Data_In=0x12345678, Data_Done at ACCESS+1, Data_Rdata unchanged.
- Both Req held high continuously -> grants alternate data, fetch, data, fetch; each separated by a 10 RELEASE cycle.
- MEM_ERROR and MEM_MFC both high in same cycle on data read -> Data_Done with Access_Error=1, Error_Sticky=1, Data_Rdata unchanged.
- MEM_TIMEOUT_EN, TIMEOUT_CYCLES=4, no MFC -> Access_Error pulse exactly 4 cycles after ACCESS entry; without macro, stays in ACCESS for 100 cycles.
- Reset asserted mid-ACCESS -> immediate MEM_r_w_z_z=10, no Done pulse, all outputs at reset values; access reissued after release.
